// File: rtl/dadda_unsigned_divider_8.sv
// Iterative restoring unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder,
// one quotient bit per clock behind a start/busy/done handshake, with divide-by-zero and overflow flags.
module dadda_unsigned_divider_8 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [2*N-1:0] dvd_r;
    logic [N-1:0]   dvs_r;
    logic [N-1:0]   rem_r;
    logic [N-1:0]   q_r;
    logic [CW-1:0]  cnt_r;

    logic [N:0]     t_s;
    logic [N-1:0]   rem_step_s;
    logic [N-1:0]   q_step_s;
    logic           ge_s;
    logic           err_zero_s;
    logic           err_ovf_s;
    logic           last_s;

    // One restoring step plus the error tests evaluated in CHECK.
    // The partial remainder stays below the divisor, so N bits hold it; the
    // shifted value T keeps its carry bit for the N+1-bit comparison.
    always_comb begin
        t_s        = {rem_r, q_r[N-1]};
        ge_s       = (t_s >= {1'b0, dvs_r});
        q_step_s   = {q_r[N-2:0], ge_s};
        err_zero_s = (dvs_r == {N{1'b0}});
        err_ovf_s  = (dvd_r[2*N-1:N] >= dvs_r);
        last_s     = (cnt_r == CW'(N - 1));
        if (ge_s) begin
            rem_step_s = t_s[N-1:0] - dvs_r;
        end else begin
            rem_step_s = t_s[N-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (err_zero_s || err_ovf_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done follow the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r       <= {(2*N){1'b0}};
            dvs_r       <= {N{1'b0}};
            rem_r       <= {N{1'b0}};
            q_r         <= {N{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            done <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_r       <= dividend;
                        dvs_r       <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (err_zero_s) begin
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        quotient    <= {N{1'b1}};
                        remainder   <= {N{1'b0}};
                    end else if (err_ovf_s) begin
                        overflow    <= 1'b1;
                        quotient    <= {N{1'b1}};
                        remainder   <= {N{1'b0}};
                    end else begin
                        rem_r <= dvd_r[2*N-1:N];
                        q_r   <= dvd_r[N-1:0];
                        cnt_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    rem_r <= rem_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        quotient  <= q_step_s;
                        remainder <= rem_step_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/dadda_unsigned_divider_8.md
Name: dadda_unsigned_divider_8

Overview:
- Iterative restoring unsigned divider. It is the inverse companion of the 8-bit unsigned multipliers: it accepts a 2N-bit dividend (e.g. a multiplier product) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder.
- Used to check multiplier results in-system and for ratio computation in the datapath.
- Processes one quotient bit per clock through a start/busy/done handshake.

Parameters:
- N, 8, operand width. Divisor, quotient and remainder are N bits; the dividend is 2N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  unsigned dividend; captured on the accepted start edge
- divisor  input  N  unsigned divisor; captured on the accepted start edge
- busy  output  1  high from the accept edge until done deasserts
- done  output  1  single-cycle pulse; results valid while done is high and held afterwards
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  divisor was 0; valid with done
- overflow  output  1  quotient does not fit in N bits (divisor != 0 and dividend[2N-1:N] >= divisor); valid with done

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; all internal registers cleared. Reset mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE -> (start) -> CHECK
  - CHECK -> (error) -> DONE
  - CHECK -> (no error) -> RUN
  - RUN -> (N steps complete) -> DONE
  - DONE -> IDLE (unconditional)
- Accept: on a clk edge in IDLE with start=1, capture dividend and divisor, clear div_by_zero and overflow, set busy=1, go to CHECK.
- CHECK, one cycle:
  - divisor==0: div_by_zero=1, overflow=0, quotient=all ones, remainder=0, go to DONE.
  - Else if dividend[2N-1:N] >= divisor: overflow=1, quotient=all ones, remainder=0, go to DONE.
  - Else: load partial remainder R (N+1 bits) = dividend[2N-1:N], shift register Q = dividend[N-1:0], step counter=0, go to RUN.
- RUN step, one per cycle, N cycles:
  - T = {R[N-1:0], Q[N-1]}.
  - If T >= {0,divisor}: R = T - divisor, Q = {Q[N-2:0],1}.
  - Else: R = T, Q = {Q[N-2:0],0}.
  - Increment counter. After step N, register quotient=Q and remainder=R[N-1:0], then go to DONE.
- DONE, one cycle: done=1, busy=1. On the next edge, done=0, busy=0, state=IDLE.
- Latency:
  - Normal: accept edge k -> done high during the cycle after edge k+N+1 (N+2 cycles total, 10 for N=8).
  - Error: done high after edge k+1.
  - Minimum start-to-start spacing is N+3 cycles; start may be asserted again in the first IDLE cycle after done.
- start while busy (CHECK, RUN or DONE) is ignored; operand inputs may change freely while busy.
- quotient, remainder and flags hold their last values until the next CHECK/RUN completion or reset.
- Invariant when no error: dividend == quotient*divisor + remainder, and remainder < divisor.
- Arithmetic is unsigned only, with no rounding. Comparisons use N+1-bit width so the carry out of the shift is never lost.

Test Plan:
- After reset release: all outputs 0. Then dividend=11270 (0x2C06), divisor=115 (0x73), pulse start -> done pulse exactly 10 cycles after accept; quotient=98 (0x62), remainder=0, both flags 0.
- Back-to-back normal ops, each started the first cycle after done:
  - 16835/99 -> q=170, r=5.
  - 9659/42 -> q=229, r=41.
  - Confirm busy stays high continuously through each op and done lasts exactly 1 cycle.
- Boundaries:
  - 65279/255 -> q=255, r=254, overflow=0.
  - 65535/255 -> overflow=1, q=255, r=0, done 2 cycles after accept.
  - 0/7 -> q=0, r=0.
  - 6/7 -> q=0, r=6.
- Errors:
  - 0x1234/0x12 -> overflow=1, div_by_zero=0.
  - 500/0 -> div_by_zero=1, overflow=0, q=255, r=0; done 2 cycles after accept.
- Protocol: re-assert start with different operands during RUN, and change the operand inputs -> ignored; the result matches the originally captured operands and no extra done pulse occurs.
- Reset mid-operation: assert rst_n low at step 4 of 11270/115 -> all outputs 0 immediately (asynchronous) and no done pulse. After release, a new op 16835/99 completes correctly.
